prog_loader: RTL and testbench

- Program/data memory plus host load front-end sitting directly upstream of the processor core's memory port.
- 2^ADDR_W x 15-bit word memory. Accepts a byte-stream command protocol from an off-chip host to load, dump and start/stop programs.
- Holds the core in reset until a RUN command arrives.
- While running, serves the core's combinational reads and its 8-bit stores.

---
 rtl/prog_loader.sv | 187 ++++++++++++++++++
 tb/tb_prog_loader.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// Host byte-stream loader, dumper and run control in front of a 2^ADDR_W x 15-bit memory.
// State moves on ph2, registered outputs follow on ph1; core reads are combinational.
module prog_loader #(
  parameter int ADDR_W = 8,
  parameter int WORD_W = 15
) (
  input  logic              ph1,
  input  logic              ph2,
  input  logic              reset,
  input  logic              host_valid,
  input  logic [7:0]        host_data,
  output logic              host_ready,
  output logic              out_valid,
  output logic [7:0]        out_data,
  input  logic              out_ready,
  output logic              cpu_reset,
  input  logic [ADDR_W-1:0] Adr,
  input  logic              MemWrite,
  input  logic [7:0]        WriteData,
  output logic [6:0]        MemData1,
  output logic [7:0]        MemData2
);

  localparam int CW = ADDR_W + 1;
  localparam logic [7:0] CMD_LOAD = 8'h01;
  localparam logic [7:0] CMD_RUN  = 8'h02;
  localparam logic [7:0] CMD_DUMP = 8'h03;
  localparam logic [7:0] CMD_HALT = 8'h04;
  localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);
  localparam logic [CW-1:0]     CNT_ONE = CW'(1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LD_CNT = 3'd1,
    LD_HI  = 3'd2,
    LD_LO  = 3'd3,
    DP_CNT = 3'd4,
    DP_HI  = 3'd5,
    DP_LO  = 3'd6,
    RUN    = 3'd7
  } state_t;

  state_t              state;
  logic [ADDR_W-1:0]   ptr;
  logic [CW-1:0]       remaining;
  logic [6:0]          hi_hold;
  logic [WORD_W-1:0]   mem [2**ADDR_W];

  logic                host_fire;
  logic                out_fire;
  logic [8:0]          cnt_wide;
  logic [CW-1:0]       cnt_n;
  logic                last_word;

  logic                mem_we;
  logic [ADDR_W-1:0]   mem_wa;
  logic [WORD_W-1:0]   mem_wd;

  logic                ready_n;
  logic                valid_n;
  logic [7:0]          data_n;
  logic                cpu_rst_n;

  assign host_fire = host_valid & host_ready;
  assign out_fire  = out_valid & out_ready;

  // A count byte of zero stands for 256 words.
  assign cnt_wide  = (host_data == 8'd0) ? 9'd256 : {1'b0, host_data};
  assign cnt_n     = CW'(cnt_wide);
  assign last_word = (remaining == CNT_ONE);

  assign MemData1 = mem[Adr][WORD_W-1:8];
  assign MemData2 = mem[Adr][7:0];

  always_ff @(posedge ph2) begin
    if (reset) begin
      state     <= IDLE;
      ptr       <= '0;
      remaining <= '0;
      hi_hold   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (host_fire) begin
            case (host_data)
              CMD_LOAD: state <= LD_CNT;
              CMD_RUN:  state <= RUN;
              CMD_DUMP: state <= DP_CNT;
              default:  state <= IDLE;
            endcase
          end
        end
        LD_CNT: begin
          if (host_fire) begin
            ptr       <= '0;
            remaining <= cnt_n;
            state     <= LD_HI;
          end
        end
        LD_HI: begin
          if (host_fire) begin
            hi_hold <= host_data[6:0];
            state   <= LD_LO;
          end
        end
        LD_LO: begin
          if (host_fire) begin
            ptr       <= ptr + PTR_ONE;
            remaining <= remaining - CNT_ONE;
            state     <= last_word ? IDLE : LD_HI;
          end
        end
        DP_CNT: begin
          if (host_fire) begin
            ptr       <= '0;
            remaining <= cnt_n;
            state     <= DP_HI;
          end
        end
        DP_HI: begin
          if (out_fire) state <= DP_LO;
        end
        DP_LO: begin
          if (out_fire) begin
            ptr       <= ptr + PTR_ONE;
            remaining <= remaining - CNT_ONE;
            state     <= last_word ? IDLE : DP_HI;
          end
        end
        RUN: begin
          if (host_fire && host_data == CMD_HALT) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Host loads and core stores live in disjoint states, so one write port suffices.
  always_comb begin
    mem_we = 1'b0;
    mem_wa = ptr;
    mem_wd = {hi_hold, host_data};
    if (!reset) begin
      if (state == LD_LO && host_fire) begin
        mem_we = 1'b1;
      end else if (state == RUN && MemWrite) begin
        mem_we = 1'b1;
        mem_wa = Adr;
        mem_wd = {mem[Adr][WORD_W-1:8], WriteData};
      end
    end
  end

  always_ff @(posedge ph2) begin
    if (mem_we) mem[mem_wa] <= mem_wd;
  end

  always_comb begin
    ready_n   = 1'b1;
    valid_n   = 1'b0;
    data_n    = 8'd0;
    cpu_rst_n = 1'b1;
    case (state)
      DP_HI: begin
        ready_n = 1'b0;
        valid_n = 1'b1;
        data_n  = {1'b0, mem[ptr][WORD_W-1:8]};
      end
      DP_LO: begin
        ready_n = 1'b0;
        valid_n = 1'b1;
        data_n  = mem[ptr][7:0];
      end
      RUN:     cpu_rst_n = 1'b0;
      default: ;
    endcase
  end

  // ptr and memory are frozen during a dump, so out_data holds across stalls.
  always_ff @(posedge ph1) begin
    host_ready <= ready_n;
    out_valid  <= valid_n;
    out_data   <= data_n;
    cpu_reset  <= cpu_rst_n;
  end

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: scripted host traffic with a memory model and a dump-byte scoreboard.
module tb_prog_loader;

  logic       ph1 = 1'b0;
  logic       ph2 = 1'b0;
  logic       reset = 1'b1;
  logic       host_valid = 1'b0;
  logic [7:0] host_data = 8'd0;
  logic       host_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready = 1'b0;
  logic       cpu_reset;
  logic [7:0] Adr = 8'd0;
  logic       MemWrite = 1'b0;
  logic [7:0] WriteData = 8'd0;
  logic [6:0] MemData1;
  logic [7:0] MemData2;

  int checks = 0;
  int errors = 0;

  logic [14:0] model [256];
  logic [14:0] stage [256];
  logic [7:0]  exp_q [$];

  prog_loader #(.ADDR_W(8), .WORD_W(15)) dut (
    .ph1(ph1), .ph2(ph2), .reset(reset),
    .host_valid(host_valid), .host_data(host_data), .host_ready(host_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .cpu_reset(cpu_reset),
    .Adr(Adr), .MemWrite(MemWrite), .WriteData(WriteData),
    .MemData1(MemData1), .MemData2(MemData2)
  );

  // Non-overlapping phases: ph1 high 1..4, ph2 high 6..9 of each 10-unit cycle.
  initial begin
    forever begin
      #1 ph1 = 1'b1;
      #3 ph1 = 1'b0;
      #2 ph2 = 1'b1;
      #3 ph2 = 1'b0;
      #1;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic step;
    @(posedge ph2);
    @(posedge ph1);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    host_valid = 1'b1;
    host_data  = b;
    while (host_ready !== 1'b1 && n < 20) begin
      step;
      n++;
    end
    if (n >= 20) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: host_ready=%b byte=%h, required ready within 20 cycles", host_ready, b);
    end
    step;
    host_valid = 1'b0;
  endtask

  task automatic load_stage(input int n);
    send_byte(8'h01);
    send_byte(8'(n));
    for (int i = 0; i < n; i++) begin
      send_byte({1'b0, stage[i][14:8]});
      send_byte(stage[i][7:0]);
      model[i] = stage[i];
    end
  endtask

  task automatic start_dump(input int n);
    int cnt;
    cnt = (n == 0) ? 256 : n;
    send_byte(8'h03);
    send_byte(8'(n));
    for (int i = 0; i < cnt; i++) begin
      exp_q.push_back({1'b0, model[i][14:8]});
      exp_q.push_back(model[i][7:0]);
    end
  endtask

  // Drains the scoreboard; toggle selects the 1,0,0,1 out_ready pattern.
  task automatic collect_dump(input bit toggle, input string tag);
    int cyc;
    bit stalled;
    logic [7:0] prev;
    logic [7:0] exp_b;
    logic pat [4];
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
    cyc = 0;
    stalled = 1'b0;
    prev = 8'd0;
    while (exp_q.size() > 0 && cyc < 3000) begin
      out_ready = toggle ? pat[cyc % 4] : 1'b1;
      checks++;
      if (host_ready !== 1'b0) begin
        errors++;
        $display("FAIL %s_host_ready: got %b during dump, required 0", tag, host_ready);
      end
      if (stalled) begin
        checks++;
        if (out_data !== prev) begin
          errors++;
          $display("FAIL %s_stall_hold: out_data=%h, required held %h", tag, out_data, prev);
        end
      end
      if (!toggle) begin
        checks++;
        if (out_valid !== 1'b1) begin
          errors++;
          $display("FAIL %s_gap: out_valid=%b at cycle %0d, required 1", tag, out_valid, cyc);
        end
      end
      if (out_valid === 1'b1 && out_ready) begin
        exp_b = exp_q.pop_front();
        checks++;
        if (out_data !== exp_b) begin
          errors++;
          $display("FAIL %s_byte: out_data=%h, required %h (left %0d)", tag, out_data, exp_b, exp_q.size());
        end
        stalled = 1'b0;
      end else if (out_valid === 1'b1) begin
        stalled = 1'b1;
        prev = out_data;
      end
      step;
      cyc++;
    end
    out_ready = 1'b0;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_timeout: %0d bytes not seen, required 0", tag, exp_q.size());
      exp_q.delete();
    end
    checks++;
    if (out_valid !== 1'b0 || host_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_end: out_valid=%b host_ready=%b, required 0/1", tag, out_valid, host_ready);
    end
  endtask

  task automatic check_mem(input logic [7:0] a, input string tag);
    Adr = a;
    #1;
    checks++;
    if (MemData1 !== model[a][14:8] || MemData2 !== model[a][7:0]) begin
      errors++;
      $display("FAIL %s: mem[%h]=%h_%h, required %h_%h", tag, a, MemData1, MemData2,
               model[a][14:8], model[a][7:0]);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    step;
    step;
    reset = 1'b0;
    checks++;
    if (cpu_reset !== 1'b1 || host_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 8'd0) begin
      errors++;
      $display("FAIL reset_outputs: cpu_reset=%b host_ready=%b out_valid=%b out_data=%h, required 1/1/0/00",
               cpu_reset, host_ready, out_valid, out_data);
    end
  endtask

  task automatic test_load;
    logic [7:0] seq [6];
    seq[0] = 8'h01; seq[1] = 8'h02; seq[2] = 8'h00;
    seq[3] = 8'h5A; seq[4] = 8'h7F; seq[5] = 8'h11;
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (host_ready !== 1'b1) begin
        errors++;
        $display("FAIL load_ready: host_ready=%b before byte %0d, required 1", host_ready, i);
      end
      send_byte(seq[i]);
    end
    model[0] = 15'h005A;
    model[1] = 15'h7F11;
    check_mem(8'd1, "load_word1");
    check_mem(8'd0, "load_word0");
    checks++;
    if (host_ready !== 1'b1 || cpu_reset !== 1'b1) begin
      errors++;
      $display("FAIL load_idle: host_ready=%b cpu_reset=%b, required 1/1", host_ready, cpu_reset);
    end
  endtask

  task automatic test_dump;
    start_dump(2);
    collect_dump(1'b0, "dump_full");
    start_dump(2);
    collect_dump(1'b1, "dump_stall");
  endtask

  task automatic test_wrap;
    for (int i = 0; i < 256; i++) stage[i] = {i[6:0], i[7:0]};
    load_stage(256);
    check_mem(8'd255, "wrap_last");
    check_mem(8'd0, "wrap_first");
    start_dump(0);
    collect_dump(1'b0, "dump_256");
  endtask

  task automatic test_run;
    stage[0] = 15'h1234;
    load_stage(1);
    send_byte(8'h02);
    checks++;
    if (cpu_reset !== 1'b0) begin
      errors++;
      $display("FAIL run_cpu_reset: got %b, required 0", cpu_reset);
    end
    check_mem(8'd0, "run_fetch0");
    send_byte(8'h01);
    send_byte(8'h03);
    step;
    checks++;
    if (cpu_reset !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL run_drop: cpu_reset=%b out_valid=%b, required 0/0", cpu_reset, out_valid);
    end
    Adr = 8'h40;
    WriteData = 8'h33;
    MemWrite = 1'b1;
    step;
    MemWrite = 1'b0;
    model[8'h40][7:0] = 8'h33;
    check_mem(8'h40, "run_store");
    send_byte(8'h04);
    checks++;
    if (cpu_reset !== 1'b1) begin
      errors++;
      $display("FAIL halt_cpu_reset: got %b, required 1", cpu_reset);
    end
    Adr = 8'h40;
    WriteData = 8'hAA;
    MemWrite = 1'b1;
    step;
    MemWrite = 1'b0;
    check_mem(8'h40, "halt_store_ignored");
  endtask

  task automatic test_reset_mid;
    send_byte(8'h01);
    send_byte(8'h03);
    send_byte(8'h00);
    send_byte(8'h5A);
    model[0] = 15'h005A;
    reset = 1'b1;
    step;
    reset = 1'b0;
    checks++;
    if (cpu_reset !== 1'b1 || host_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL midload_reset: cpu_reset=%b host_ready=%b out_valid=%b, required 1/1/0",
               cpu_reset, host_ready, out_valid);
    end
    check_mem(8'd0, "midload_retained");
    send_byte(8'h99);
    stage[0] = 15'h0001;
    load_stage(1);
    check_mem(8'd0, "reload_word0");
    start_dump(1);
    collect_dump(1'b0, "dump_after_reset");
    send_byte(8'h03);
    send_byte(8'h04);
    out_ready = 1'b0;
    step;
    step;
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL middump_valid: out_valid=%b, required 1", out_valid);
    end
    reset = 1'b1;
    step;
    reset = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 8'd0 || host_ready !== 1'b1 || cpu_reset !== 1'b1) begin
      errors++;
      $display("FAIL middump_reset: out_valid=%b out_data=%h host_ready=%b cpu_reset=%b, required 0/00/1/1",
               out_valid, out_data, host_ready, cpu_reset);
    end
  endtask

  initial begin
    test_reset;
    test_load;
    test_dump;
    test_wrap;
    test_run;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
